// File: rtl/aes_inv_round.sv
// AES-128 inverse cipher round with valid/ready pipeline (STAGES = 1 or 2).
// Optional completed-transfer counter on OUT_count when AES_INV_ROUND_CNT_EN is defined.
module aes_inv_round #(
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         IN_valid,
    output logic         IN_ready,
    input  logic [127:0] IN_state,
    input  logic [127:0] RoundKey,
    input  logic         IN_last,
    output logic         OUT_valid,
    input  logic         OUT_ready,
    output logic [127:0] OUT_state
`ifdef AES_INV_ROUND_CNT_EN
    ,
    output logic [31:0]  OUT_count
`endif
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = c[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    // Row r of the result takes its byte from column (c - r) mod 4; S-box lookup is bytewise.
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = r + 4 * ((c - r + 4) % 4);
                o[127-8*(r+4*c) -: 8] = INV_SBOX[s[127-8*src -: 8]];
            end
        end
        return o;
    endfunction

    logic [127:0] w_add;
    logic [127:0] w_mix;
    logic         w_out_free;
    logic         w_in_fire;
    logic         r_out_valid;
    logic [127:0] r_out_state;

    assign w_add      = IN_state ^ RoundKey;
    assign w_mix      = IN_last ? w_add : inv_mix_columns(w_add);
    assign w_out_free = !r_out_valid | OUT_ready;
    assign w_in_fire  = IN_valid & IN_ready;
    assign OUT_valid  = r_out_valid;
    assign OUT_state  = r_out_state;

    if (STAGES == 2) begin : g_two
        logic         r_s1_valid;
        logic [127:0] r_s1;

        assign IN_ready = !reset & (!r_s1_valid | w_out_free);

        always_ff @(posedge clk) begin
            if (reset) begin
                r_s1_valid  <= 1'b0;
                r_s1        <= '0;
                r_out_valid <= 1'b0;
                r_out_state <= '0;
            end else begin
                if (w_in_fire) begin
                    r_s1_valid <= 1'b1;
                    r_s1       <= w_mix;
                end else if (w_out_free) begin
                    r_s1_valid <= 1'b0;
                end
                if (w_out_free) begin
                    r_out_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_out_state <= inv_shift_sub(r_s1);
                    end
                end
            end
        end
    end else if (STAGES == 1) begin : g_one
        assign IN_ready = !reset & w_out_free;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_out_valid <= 1'b0;
                r_out_state <= '0;
            end else if (w_out_free) begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_state <= inv_shift_sub(w_mix);
                end
            end
        end
    end else begin : g_bad
        $error("aes_inv_round: STAGES must be 1 or 2");
    end

`ifdef AES_INV_ROUND_CNT_EN
    logic [31:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (r_out_valid & OUT_ready) begin
            r_count <= r_count + 32'd1;
        end
    end

    assign OUT_count = r_count;
`endif

endmodule
